// File: rtl/qe_ctrl.sv
// qe_ctrl: quadrature encoder front end (sync, glitch filter, decode, extension count, snapshots); define QE_X4_EN for x4 decoding
module qe_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 3,
  parameter int EXT_W = 12,
  parameter int ERR_LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pin,
  input  logic             q_pin,
  input  logic             clr_req,
  input  logic             snap_req,
  input  logic [3:0]       cnt_val,
  input  logic             cnt_c,
  input  logic             cnt_b,
  output logic             i,
  output logic             q,
  output logic             i_r,
  output logic             i_f,
  output logic             q_r,
  output logic             q_f,
  output logic             step,
  output logic             dir,
  output logic             update,
  output logic [EXT_W-1:0] ext,
  output logic [EXT_W+3:0] snap_val,
  output logic             snap_ack,
  output logic             err,
  output logic [3:0]       err_cnt
);
  localparam int RW = $clog2(FILT_LEN + 1);
  localparam logic [3:0] ERR_MAX = 4'(ERR_LIMIT > 15 ? 15 : ERR_LIMIT);
  typedef enum logic [1:0] {INIT, RUN, CLR} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] si_q, si_d, sq_q, sq_d;
  logic [1:0] s, samp_q, samp_d, filt_q, filt_d, prev_q, prev_d, chg;
  logic [1:0][RW-1:0] run_q, run_d;
  logic [3:0] edge_q, edge_d, err_cnt_q, err_cnt_d;
  logic step_q, step_d, dir_q, dir_d, err_q, err_d, snap_ack_q, snap_ack_d;
  logic snap_pend_q, snap_pend_d, clr_pend_q, clr_pend_d;
  logic [EXT_W-1:0] ext_q, ext_d;
  logic [EXT_W+3:0] snap_val_q, snap_val_d;
  logic run_st, service, go_clr, dec, up, illegal;
  always_comb begin
    si_d = {si_q[SYNC_STAGES-2:0], i_pin};
    sq_d = {sq_q[SYNC_STAGES-2:0], q_pin};
    s = {si_q[SYNC_STAGES-1], sq_q[SYNC_STAGES-1]};
    samp_d = s;
    run_d = run_q;
    filt_d = filt_q;
    for (int c = 0; c < 2; c++) begin
      run_d[c] = s[c] != samp_q[c] ? RW'(1) : run_q[c] == RW'(FILT_LEN) ? run_q[c] : run_q[c] + RW'(1);
      filt_d[c] = run_d[c] == RW'(FILT_LEN) ? s[c] : filt_q[c];
    end
    run_st = state_q == RUN;
    service = run_st & snap_pend_q & ~step_q;
    go_clr = run_st & clr_pend_q & ~snap_pend_q;
    dec = run_st & ~go_clr;
    chg = prev_q ^ filt_q;
    edge_d = dec & (^chg) ? {chg[1] & filt_q[1], chg[1] & ~filt_q[1], chg[0] & filt_q[0], chg[0] & ~filt_q[0]} : 4'b0;
    illegal = dec & (&chg);
    up = edge_d[3] & ~filt_q[0] | edge_d[2] & filt_q[0] | edge_d[1] & filt_q[1] | edge_d[0] & ~filt_q[1];
`ifdef QE_X4_EN
    step_d = |edge_d;
`else
    step_d = |edge_d[3:2];
`endif
    dir_d = step_d & up;
    ext_d = !run_st ? '0 : cnt_c & ~cnt_b ? ext_q + EXT_W'(1) : cnt_b & ~cnt_c ? ext_q - EXT_W'(1) : ext_q;
    err_d = run_st & (err_q | illegal | cnt_c & cnt_b);
    err_cnt_d = !run_st ? 4'd0 : illegal & err_cnt_q < ERR_MAX ? err_cnt_q + 4'd1 : err_cnt_q;
    snap_pend_d = (snap_pend_q | snap_req) & ~service;
    clr_pend_d = (clr_pend_q | clr_req) & ~go_clr;
    snap_val_d = service ? {ext_q, cnt_val} : snap_val_q;
    snap_ack_d = service;
    prev_d = filt_q;
    state_d = go_clr ? CLR : RUN;
  end
  always_ff @(posedge clk) begin
    si_q <= si_d;
    sq_q <= sq_d;
    if (rst) begin
      state_q <= INIT;
      samp_q <= s;
      filt_q <= s;
      run_q <= '0;
      prev_q <= '0;
      edge_q <= '0;
      step_q <= 1'b0;
      dir_q <= 1'b0;
      ext_q <= '0;
      err_q <= 1'b0;
      err_cnt_q <= '0;
      snap_pend_q <= 1'b0;
      clr_pend_q <= 1'b0;
      snap_val_q <= '0;
      snap_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q <= samp_d;
      filt_q <= filt_d;
      run_q <= run_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
      step_q <= step_d;
      dir_q <= dir_d;
      ext_q <= ext_d;
      err_q <= err_d;
      err_cnt_q <= err_cnt_d;
      snap_pend_q <= snap_pend_d;
      clr_pend_q <= clr_pend_d;
      snap_val_q <= snap_val_d;
      snap_ack_q <= snap_ack_d;
    end
  end
  assign i = filt_q[1] & (state_q != INIT);
  assign q = filt_q[0] & (state_q != INIT);
  assign {i_r, i_f, q_r, q_f} = edge_q;
  assign step = step_q;
  assign dir = dir_q;
  assign update = state_q != RUN;
  assign ext = ext_q;
  assign snap_val = snap_val_q;
  assign snap_ack = snap_ack_q;
  assign err = err_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_qe_ctrl.sv
// tb_qe_ctrl: directed vector table plus hand sequences for qe_ctrl
module tb_qe_ctrl;
`ifdef QE_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif
  logic clk = 0, rst = 1, i_pin = 1, q_pin = 1, clr_req = 0, snap_req = 0, cnt_c = 0, cnt_b = 0;
  logic [3:0] cnt_val = 0;
  logic i, q, i_r, i_f, q_r, q_f, step, dir, update, snap_ack, err;
  logic [11:0] ext;
  logic [15:0] snap_val;
  logic [3:0] err_cnt;
  int n_chk = 0, n_bad = 0;
  int c_ir, c_if, c_qr, c_qf, c_step, c_up, c_upd;
  typedef struct {
    int ip, qp, c, b, clr, hold, pulses, up, ei, eq, eext, eerr, ecnt, eupd;
  } vec_t;
  vec_t tv [16];
  qe_ctrl dut (
    .clk(clk), .rst(rst), .i_pin(i_pin), .q_pin(q_pin), .clr_req(clr_req), .snap_req(snap_req),
    .cnt_val(cnt_val), .cnt_c(cnt_c), .cnt_b(cnt_b), .i(i), .q(q), .i_r(i_r), .i_f(i_f),
    .q_r(q_r), .q_f(q_f), .step(step), .dir(dir), .update(update), .ext(ext),
    .snap_val(snap_val), .snap_ack(snap_ack), .err(err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic clr_counts;
    c_ir = 0; c_if = 0; c_qr = 0; c_qf = 0; c_step = 0; c_up = 0; c_upd = 0;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    c_ir += int'(i_r); c_if += int'(i_f); c_qr += int'(q_r); c_qf += int'(q_f);
    c_step += int'(step); c_up += int'(step & dir); c_upd += int'(update);
  endtask
  function automatic int pulses();
    return (c_ir << 12) | (c_if << 8) | (c_qr << 4) | c_qf;
  endfunction
  initial begin
    int es, t_i, t_r, maxi, found;
    // ip qp c b clr hold pulses up ei eq ext err ecnt upd
    tv[0]  = '{0, 1, 0, 0, 0, 8, 'h0100, 1, 0, 1, 'h000, 0, 0, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 8, 'h0001, 1, 0, 0, 'h000, 0, 0, 0};
    tv[2]  = '{1, 0, 0, 0, 0, 8, 'h1000, 1, 1, 0, 'h000, 0, 0, 0};
    tv[3]  = '{1, 1, 0, 0, 0, 8, 'h0010, 1, 1, 1, 'h000, 0, 0, 0};
    tv[4]  = '{0, 1, 0, 0, 0, 8, 'h0100, 1, 0, 1, 'h000, 0, 0, 0};
    tv[5]  = '{0, 0, 0, 0, 0, 8, 'h0001, 1, 0, 0, 'h000, 0, 0, 0};
    tv[6]  = '{0, 1, 0, 0, 0, 8, 'h0010, 0, 0, 1, 'h000, 0, 0, 0};
    tv[7]  = '{1, 1, 0, 0, 0, 8, 'h1000, 0, 1, 1, 'h000, 0, 0, 0};
    tv[8]  = '{1, 0, 0, 0, 0, 8, 'h0001, 0, 1, 0, 'h000, 0, 0, 0};
    tv[9]  = '{0, 0, 0, 0, 0, 8, 'h0100, 0, 0, 0, 'h000, 0, 0, 0};
    tv[10] = '{0, 0, 0, 1, 0, 2, 'h0000, 0, 0, 0, 'hFFF, 0, 0, 0};
    tv[11] = '{0, 0, 1, 0, 0, 2, 'h0000, 0, 0, 0, 'h000, 0, 0, 0};
    tv[12] = '{0, 0, 0, 1, 0, 2, 'h0000, 0, 0, 0, 'hFFF, 0, 0, 0};
    tv[13] = '{0, 0, 1, 1, 0, 2, 'h0000, 0, 0, 0, 'hFFF, 1, 0, 0};
    tv[14] = '{0, 0, 0, 0, 1, 4, 'h0000, 0, 0, 0, 'h000, 0, 0, 1};
    tv[15] = '{1, 1, 0, 0, 0, 8, 'h0000, 0, 1, 1, 'h000, 1, 1, 0};
    clr_counts();
    repeat (3) tick();
    chk("rst update", int'(update), 1);
    chk("rst ext", int'(ext), 0);
    chk("rst err", int'(err), 0);
    chk("rst i", int'(i), 0);
    chk("rst pulses", pulses() + c_step, 0);
    rst = 0;
    chk("init update", int'(update), 1);
    clr_counts();
    tick();
    chk("run update", int'(update), 0);
    chk("run iq", int'({i, q}), 3);
    repeat (7) tick();
    chk("post-reset pulses", pulses() + c_step, 0);
    chk("post-reset err", int'(err), 0);
    for (int k = 0; k < 16; k++) begin
      i_pin = 1'(tv[k].ip);
      q_pin = 1'(tv[k].qp);
      cnt_c = 1'(tv[k].c);
      cnt_b = 1'(tv[k].b);
      clr_req = 1'(tv[k].clr);
      clr_counts();
      tick();
      cnt_c = 0; cnt_b = 0; clr_req = 0;
      repeat (tv[k].hold - 1) tick();
      es = ((tv[k].pulses >> 12) & 15) + ((tv[k].pulses >> 8) & 15)
         + (X4 ? ((tv[k].pulses >> 4) & 15) + (tv[k].pulses & 15) : 0);
      chk($sformatf("v%0d pulses", k), pulses(), tv[k].pulses);
      chk($sformatf("v%0d steps", k), c_step, es);
      chk($sformatf("v%0d up", k), c_up, tv[k].up != 0 ? es : 0);
      chk($sformatf("v%0d i", k), int'(i), tv[k].ei);
      chk($sformatf("v%0d q", k), int'(q), tv[k].eq);
      chk($sformatf("v%0d ext", k), int'(ext), tv[k].eext);
      chk($sformatf("v%0d err", k), int'(err), tv[k].eerr);
      chk($sformatf("v%0d err_cnt", k), int'(err_cnt), tv[k].ecnt);
      chk($sformatf("v%0d update", k), c_upd, tv[k].eupd);
    end
    clr_counts();
    for (int k = 0; k < 19; k++) begin
      i_pin = ~i_pin;
      q_pin = ~q_pin;
      repeat (8) tick();
    end
    chk("illegal pulses", pulses() + c_step, 0);
    chk("illegal sat", int'(err_cnt), 15);
    chk("illegal err", int'(err), 1);
    clr_counts();
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (3) tick();
    chk("clr err", int'(err), 0);
    chk("clr err_cnt", int'(err_cnt), 0);
    chk("clr update", c_upd, 1);
    clr_counts();
    t_i = 0; t_r = 0;
    i_pin = 1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t_i == 0 && i) t_i = t;
      if (t_r == 0 && i_r) t_r = t;
    end
    chk("latency i", t_i, 5);
    chk("latency i_r", t_r, 6);
    i_pin = 0;
    repeat (10) tick();
    clr_counts();
    maxi = 0;
    i_pin = 1;
    repeat (2) begin tick(); maxi |= int'(i); end
    i_pin = 0;
    repeat (10) begin tick(); maxi |= int'(i); end
    chk("glitch2 pulses", pulses() + c_step, 0);
    chk("glitch2 i", maxi, 0);
    clr_counts();
    i_pin = 1;
    repeat (4) tick();
    i_pin = 0;
    repeat (12) tick();
    chk("glitch4 i_r", c_ir, 1);
    chk("glitch4 i_f", c_if, 1);
    cnt_val = 7;
    found = 0;
    i_pin = 1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (step) begin found = 1; break; end
    end
    chk("snap step seen", found, 1);
    chk("snap step dir", int'(dir), 1);
    snap_req = 1;
    tick();
    snap_req = 0;
    cnt_val = 8;
    chk("snap ack early", int'(snap_ack), 0);
    tick();
    chk("snap ack", int'(snap_ack), 1);
    chk("snap val", int'(snap_val), 'h0008);
    tick();
    chk("snap ack once", int'(snap_ack), 0);
    cnt_c = 1;
    tick();
    cnt_c = 0;
    cnt_val = 5;
    tick();
    chk("pre-clr ext", int'(ext), 1);
    snap_req = 1;
    clr_req = 1;
    tick();
    snap_req = 0;
    clr_req = 0;
    tick();
    chk("snapclr ack", int'(snap_ack), 1);
    chk("snapclr val", int'(snap_val), 'h0015);
    chk("snapclr upd early", int'(update), 0);
    tick();
    chk("snapclr update", int'(update), 1);
    tick();
    chk("snapclr ext", int'(ext), 0);
    chk("snapclr upd end", int'(update), 0);
    cnt_c = 1;
    cnt_b = 1;
    tick();
    cnt_c = 0;
    cnt_b = 0;
    chk("cb err", int'(err), 1);
    rst = 1;
    tick();
    chk("mid rst update", int'(update), 1);
    chk("mid rst err", int'(err), 0);
    chk("mid rst snap", int'(snap_val), 0);
    tick();
    rst = 0;
    chk("mid init update", int'(update), 1);
    clr_counts();
    repeat (8) tick();
    chk("mid run update", c_upd, 0);
    chk("mid run pulses", pulses() + c_step, 0);
    chk("mid run iq", int'({i, q}), 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/qe_ctrl.md
Name: qe_ctrl

Overview:
Front-end controller and sequencer for the 4-bit quadrature counter.
- Synchronises and glitch-filters the raw I/Q encoder pins.
- Decodes Gray-code transitions into single-cycle edge pulses plus step/dir.
- Drives the counter's update (clear) strobe.
- Extends the count width from the counter's carry/borrow flags and serves coherent host snapshots.

Parameters:
SYNC_STAGES, 2, synchroniser flops per pin (min 2)
FILT_LEN, 3, consecutive equal synchronised samples required before a filtered level changes (min 1)
EXT_W, 12, width of extension count above the counter's 4 bits
ERR_LIMIT, 15, saturation value of err_cnt

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_pin  in  1  raw I channel, asynchronous
q_pin  in  1  raw Q channel, asynchronous
clr_req  in  1  host pulse: clear position and errors
snap_req  in  1  host pulse: request snapshot
cnt_val  in  4  counter value y3..y0
cnt_c  in  1  counter carry
cnt_b  in  1  counter borrow
i, q  out  1 each  filtered levels
i_r, i_f, q_r, q_f  out  1 each  single-cycle edge pulses
step  out  1  valid count event this cycle
dir  out  1  1 = up, 0 = down; valid when step=1
update  out  1  counter clear strobe
ext  out  EXT_W  extension count
snap_val  out  EXT_W+4  {ext, cnt_val} captured
snap_ack  out  1  one-cycle pulse, snap_val valid
err  out  1  sticky illegal-transition flag
err_cnt  out  4  saturating illegal-transition count

Behaviour:
Reset values while rst=1, held the cycle rst falls:
- All outputs 0, except update=1.
- FSM = INIT.
- Pending flags cleared.
- Filter counters cleared.

FSM states:
- INIT (1 cycle): update=1, ext=0; prev{i,q} loaded from current filtered levels with no pulses; go to RUN.
- RUN: normal operation.
- CLR (1 cycle): update=1; ext, err, err_cnt cleared; prev reloaded; no step; go to RUN.

Filter:
- Per channel, a candidate counter resets whenever the synchronised sample differs from the previous sample.
- The filtered level takes the sample after FILT_LEN equal samples.
- A pin change held stable moves the filtered level SYNC_STAGES+FILT_LEN cycles later.
- Edge pulses are registered and appear 1 cycle after the filtered level changes.
- Glitches shorter than FILT_LEN cycles produce no change.

Decode (RUN only), from prev vs current filtered {i,q}:
- Exactly one channel changed: the matching pulse is asserted and step=1.
- dir=1 for (i_r&~q)|(i_f&q)|(q_r&i)|(q_f&~i), using the other channel's level; otherwise dir=0.
- Both channels changed: no pulses, step=0, err<=1, err_cnt increments and saturates at min(ERR_LIMIT,15).
- No change: step=0. The counter must be gated by step.

Extension count:
- cnt_c=1 → ext+1, modulo 2^EXT_W.
- cnt_b=1 → ext-1, modulo 2^EXT_W.
- Both asserted in the same cycle → ext unchanged and err<=1.

Snapshot:
- snap_req sets snap_pend.
- Serviced in the first RUN cycle where snap_pend=1 and step was 0 in the previous cycle, so the counter has settled.
- In that cycle snap_val<={ext,cnt_val}, snap_pend clears, and snap_ack pulses the next cycle.
- snap_req while already pending is merged into the pending request.

Clear:
- clr_req sets clr_pend.
- Enters CLR on the first RUN cycle in which no snapshot is being serviced, so a snapshot pending in the same cycle captures the pre-clear value first.
- An edge decoded in the cycle CLR is entered is discarded.

Reset mid-operation: aborts everything and returns to INIT regardless of state.

Optional Feature:
QE_X4_EN
- Defined: x4 decoding; all four edge types assert step.
- Undefined: x2 decoding; only i_r/i_f assert step, while q_r/q_f pulses are still output and dir is unchanged for I edges.
- Illegal-transition detection is identical in both builds.

Test Plan:
- Reset then INIT: rst 3 cycles → update=1 through the cycle after rst falls, then 0; ext=0, err=0, no pulses with i_pin=q_pin=1 at reset.
- Forward sequence (defaults, X4): IQ 00→10→11→01→00, each held 8 cycles → four step pulses with dir=1; i_r appears exactly 6 cycles after the i_pin change.
- Glitch rejection: i_pin high for 2 cycles then low → no pulses, i stays 0; high for 4 cycles → i_r once.
- Illegal transition: IQ 00→11 in one cycle → no step, err=1, err_cnt=1; 20 such events → err_cnt=15; clr_req → err=0, err_cnt=0, update pulsed once.
- Extension wrap: ext=0xFFF with cnt_c pulse → ext=0x000; cnt_b pulse → ext=0xFFF; cnt_c and cnt_b together → ext held, err=1.
- Snapshot coherence: snap_req in the same cycle as step, with cnt_val moving 7→8 next cycle → snap_val low nibble=8, snap_ack 2 cycles after step; snap_req and clr_req together → snap_val holds the pre-clear value, then update=1.
